grid_config_ctrl: RTL

// - Sequences and configures the scope background grid renderer: holds the active grid/tick preset,

---
 rtl/grid_config_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/grid_config_ctrl.sv
// grid_config_ctrl: background grid/tick renderer for the scope display.
// Holds the active grid/tick preset, collects user edits into a pending copy and
// commits them only at frame end so a frame is never drawn with mixed settings.
// Optional feature macro: AUTO_CYCLE_EN (automatic preset stepping every AUTO_FRAMES frames).
module grid_config_ctrl #(
  parameter int unsigned H_LAST    = 1687,
  parameter int unsigned V_LAST    = 1065,
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned V_ACTIVE  = 1024,
  parameter int unsigned X_CENTRE  = 640,
  parameter int unsigned Y_CENTRE  = 512,
  parameter int unsigned TICK_HALF = 4
`ifdef AUTO_CYCLE_EN
  ,
  parameter int unsigned AUTO_FRAMES = 120
`endif
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [11:0] VGA_HORZ_COORD,
  input  logic [11:0] VGA_VERT_COORD,
  input  logic        BTN_NEXT,
  input  logic        BTN_PREV,
  input  logic        BTN_TICKS,
  output logic [1:0]  PRESET,
  output logic        TICKS_ON,
  output logic        CFG_UPDATE,
  output logic [3:0]  VGA_Red_Grid,
  output logic [3:0]  VGA_Green_Grid,
  output logic [3:0]  VGA_Blue_Grid
);

  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] C_H_LAST   = CW'(H_LAST);
  localparam logic [CW-1:0] C_V_LAST   = CW'(V_LAST);
  localparam logic [CW-1:0] C_H_ACTIVE = CW'(H_ACTIVE);
  localparam logic [CW-1:0] C_V_ACTIVE = CW'(V_ACTIVE);
  localparam logic [CW-1:0] C_H_EDGE   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] C_V_EDGE   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] C_X_LO     = CW'(X_CENTRE - TICK_HALF);
  localparam logic [CW-1:0] C_X_HI     = CW'(X_CENTRE + TICK_HALF);
  localparam logic [CW-1:0] C_Y_LO     = CW'(Y_CENTRE - TICK_HALF);
  localparam logic [CW-1:0] C_Y_HI     = CW'(Y_CENTRE + TICK_HALF);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_preset;
  logic [1:0]      r_pend_preset;
  logic            r_ticks;
  logic            r_pend_ticks;
  logic            r_cfg_update;
  logic [CW-1:0]   r_cx;
  logic [CW-1:0]   r_cy;
  logic [CW-1:0]   r_tx;
  logic [CW-1:0]   r_ty;
  logic [3:0]      r_red;
  logic [3:0]      r_green;
  logic [3:0]      r_blue;

  logic [CW-1:0]   w_grid_x;
  logic [CW-1:0]   w_grid_y;
  logic [CW-1:0]   w_tick_x;
  logic [CW-1:0]   w_tick_y;
  logic [CW-1:0]   w_cx;
  logic [CW-1:0]   w_cy;
  logic [CW-1:0]   w_tx;
  logic [CW-1:0]   w_ty;
  logic [1:0]      w_pend_preset;
  logic            w_pend_ticks;
  logic            w_differs;
  logic            w_frame_end;
  logic            w_line_end;
  logic            w_visible;
  logic            w_grid_hit;
  logic            w_tick_hit;

  assign w_frame_end = (VGA_HORZ_COORD == C_H_LAST) && (VGA_VERT_COORD == C_V_LAST);
  assign w_line_end  = (VGA_HORZ_COORD == C_H_LAST);

`ifdef AUTO_CYCLE_EN
  localparam int unsigned FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  logic [FW-1:0] r_frames;
  logic          w_btn_any;
  logic          w_auto_step;

  assign w_btn_any   = BTN_NEXT | BTN_PREV | BTN_TICKS;
  assign w_auto_step = w_frame_end && !w_btn_any && (r_frames >= FW'(AUTO_FRAMES - 1));

  // Frame-end counter; any button press restarts the auto-step interval
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_frames <= '0;
    end else if (w_btn_any || w_auto_step) begin
      r_frames <= '0;
    end else if (w_frame_end) begin
      r_frames <= r_frames + FW'(1);
    end
  end
`endif

  // Preset table lookup from the active preset
  always_comb begin
    w_grid_x = CW'(80);
    w_grid_y = CW'(64);
    w_tick_x = CW'(16);
    w_tick_y = CW'(8);
    case (r_preset)
      2'd1: begin w_grid_x = CW'(160); w_grid_y = CW'(128); w_tick_x = CW'(32); w_tick_y = CW'(16); end
      2'd2: begin w_grid_x = CW'(40);  w_grid_y = CW'(32);  w_tick_x = CW'(8);  w_tick_y = CW'(4);  end
      2'd3: begin w_grid_x = CW'(320); w_grid_y = CW'(256); w_tick_x = CW'(64); w_tick_y = CW'(32); end
      default: ;
    endcase
  end

  // Pending edits for this cycle; simultaneous NEXT and PREV cancel out
  always_comb begin
    w_pend_preset = r_pend_preset;
    w_pend_ticks  = r_pend_ticks ^ BTN_TICKS;
    if (BTN_NEXT && !BTN_PREV) begin
      w_pend_preset = r_pend_preset + 2'd1;
    end else if (BTN_PREV && !BTN_NEXT) begin
      w_pend_preset = r_pend_preset - 2'd1;
    end
`ifdef AUTO_CYCLE_EN
    else if (w_auto_step) begin
      w_pend_preset = r_preset + 2'd1;
    end
`endif
    w_differs = (w_pend_preset != r_preset) || (w_pend_ticks != r_ticks);
  end

  // Commit sequencer: pending settings become active only on the frame-end cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_preset      <= 2'd0;
      r_pend_preset <= 2'd0;
      r_ticks       <= 1'b1;
      r_pend_ticks  <= 1'b1;
      r_cfg_update  <= 1'b0;
    end else begin
      r_pend_preset <= w_pend_preset;
      r_pend_ticks  <= w_pend_ticks;
      r_cfg_update  <= 1'b0;
      case (r_state)
        S_IDLE, S_PENDING: begin
          if (!w_differs) begin
            r_state <= S_IDLE;
          end else if (w_frame_end) begin
            r_state      <= S_COMMIT;
            r_preset     <= w_pend_preset;
            r_ticks      <= w_pend_ticks;
            r_cfg_update <= 1'b1;
          end else begin
            r_state <= S_PENDING;
          end
        end
        S_COMMIT: r_state <= w_differs ? S_PENDING : S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Pitch counter values for the current pixel; >= keeps them bounded after any disturbance
  always_comb begin
    w_cx = '0;
    w_tx = '0;
    if (VGA_HORZ_COORD != '0) begin
      w_cx = (r_cx >= w_grid_x - CW'(1)) ? '0 : r_cx + CW'(1);
      w_tx = (r_tx >= w_tick_x - CW'(1)) ? '0 : r_tx + CW'(1);
    end
    w_cy = (VGA_VERT_COORD == '0) ? '0 : r_cy;
    w_ty = (VGA_VERT_COORD == '0) ? '0 : r_ty;
  end

  // Pitch counter state; row counters step on the last pixel of each line
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cx <= '0;
      r_tx <= '0;
      r_cy <= '0;
      r_ty <= '0;
    end else begin
      r_cx <= w_cx;
      r_tx <= w_tx;
      if (w_line_end) begin
        r_cy <= (w_cy >= w_grid_y - CW'(1)) ? '0 : w_cy + CW'(1);
        r_ty <= (w_ty >= w_tick_y - CW'(1)) ? '0 : w_ty + CW'(1);
      end else begin
        r_cy <= w_cy;
        r_ty <= w_ty;
      end
    end
  end

  assign w_visible  = (VGA_HORZ_COORD < C_H_ACTIVE) && (VGA_VERT_COORD < C_V_ACTIVE);
  assign w_grid_hit = w_visible && ((w_cx == '0) || (w_cy == '0) ||
                      (VGA_HORZ_COORD == C_H_EDGE) || (VGA_VERT_COORD == C_V_EDGE));
  assign w_tick_hit = r_ticks && w_visible &&
                      (((VGA_VERT_COORD >= C_Y_LO) && (VGA_VERT_COORD <= C_Y_HI) && (w_tx == '0)) ||
                       ((VGA_HORZ_COORD >= C_X_LO) && (VGA_HORZ_COORD <= C_X_HI) && (w_ty == '0)));

  // Registered pixel colour: grid green has priority over tick white
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_red   <= 4'h0;
      r_green <= 4'h0;
      r_blue  <= 4'h0;
    end else if (w_grid_hit) begin
      r_red   <= 4'h0;
      r_green <= 4'hD;
      r_blue  <= 4'h0;
    end else if (w_tick_hit) begin
      r_red   <= 4'hF;
      r_green <= 4'hF;
      r_blue  <= 4'hF;
    end else begin
      r_red   <= 4'h0;
      r_green <= 4'h0;
      r_blue  <= 4'h0;
    end
  end

  assign PRESET         = r_preset;
  assign TICKS_ON       = r_ticks;
  assign CFG_UPDATE     = r_cfg_update;
  assign VGA_Red_Grid   = r_red;
  assign VGA_Green_Grid = r_green;
  assign VGA_Blue_Grid  = r_blue;

endmodule
